unary_bounded_arith: RTL and testbench
======================================

UNARY_BOUNDED_ARITH -- requirements
Module: unary_bounded_arith

Interface
REQ-001 Parameter STREAM_LEN, default 32: unary stream length L. It SHALL be a power of two, at least 4.
REQ-002 Parameter EPSILON, default 2: deferral window for the output decision.
REQ-003 Parameter COUNT_WIDTH, default $clog2(STREAM_LEN+1): width of all ones/slot counters.
REQ-004 clk  input  1  single clock; all state updates on posedge clk.
REQ-005 reset  input  1  synchronous, active-low reset.
REQ-006 start  input  1  begins a new operation; accepted only in IDLE or DONE.
REQ-007 mode  input  2  operation select, latched on accepted start: 0 MUL, 1 scaled ADD, 2 MIN, 3 MAX.
REQ-008 a, b  input  1 each  serial unary input bits.
REQ-009 ready  input  2  per-channel bit strobe: ready[0] qualifies a, ready[1] qualifies b.
REQ-010 y  output  1  serial unary result bit.
REQ-011 valid  output  1  high for one cycle when y carries a new result bit.
REQ-012 done  output  1  high while in DONE.
REQ-013 result_ones  output  COUNT_WIDTH  running count of emitted ones.
REQ-014 err  output  1  sticky flag: a strobe arrived on a channel that had already received L bits.

Function
REQ-015 FSM states SHALL be IDLE, RUN, FLUSH and DONE; reset enters IDLE.
REQ-016 start in IDLE or DONE SHALL do all of the following: go to RUN, latch mode, clear a_ones, a_cnt, b_ones, b_cnt, y_cnt, result_ones and err; start in RUN or FLUSH SHALL be ignored.
REQ-017 In RUN, ready[i] with that channel's count < L SHALL increment the count by 1 and the ones counter by the bit value; the channels SHALL update independently in the same cycle.
REQ-018 ready[i] with that channel's count == L SHALL be dropped and SHALL set err. err SHALL also be set if this happens in FLUSH or DONE.
REQ-019 Per-input bounds SHALL be: lo_x = x_ones, hi_x = x_ones + (L - x_cnt).
REQ-020 Result bounds by mode (intermediate width 2*COUNT_WIDTH, no overflow):
- MUL: lo = (lo_a*lo_b) >> log2(L); hi = (hi_a*hi_b + L-1) >> log2(L).
- ADD: lo = (lo_a+lo_b) >> 1; hi = (hi_a+hi_b+1) >> 1.
- MIN: lo = min(lo_a,lo_b); hi = min(hi_a,hi_b).
- MAX: lo = max(lo_a,lo_b); hi = max(hi_a,hi_b).
REQ-021 In RUN, a decision SHALL occur only in cycles with |ready and y_cnt < L, using the bounds before that cycle's input update.
REQ-022 Decision priority (r = result_ones, dl = r - lo, dh = hi - r):
- P1: if r < lo, emit 1.
- P2: else if r >= hi, emit 0.
- P3: else if |dl - dh| <= EPSILON, defer (no emission).
- P4: else emit 1 if dl < dh, otherwise emit 0.
REQ-023 Emit SHALL mean: on the next edge y = bit, valid = 1, y_cnt+1, and result_ones+1 if bit = 1. Defer or no decision SHALL mean valid = 0 next cycle; y holds its last value.
REQ-024 RUN SHALL go to FLUSH when a_cnt == L and b_cnt == L and y_cnt < L; it SHALL go directly to DONE if y_cnt == L at that point.
REQ-025 In FLUSH (lo == hi), one bit SHALL be emitted every cycle regardless of ready: 1 if result_ones < lo, otherwise 0. FLUSH SHALL go to DONE on the cycle y_cnt reaches L.
REQ-026 If y_cnt reaches L in RUN before both inputs are complete, no further bits SHALL be emitted. The FSM SHALL stay in RUN (input counting continues) until both inputs are complete, then go to DONE.
REQ-027 Latency: the first y bit SHALL appear one cycle after the deciding ready cycle. done SHALL assert the cycle after the final emission.
REQ-028 result_ones and y_cnt SHALL never exceed L.

Reset
REQ-029 reset low at a clock edge SHALL force, from any state including mid-RUN or mid-FLUSH: IDLE, y=0, valid=0, done=0, err=0, result_ones=0, all internal counters 0, mode=MUL.
REQ-030 ready, a and b SHALL be ignored in IDLE and DONE, except for the err rule in DONE.

Verification
REQ-031 Reset: hold reset low 2 cycles with random inputs -> y=0, valid=0, done=0, err=0, result_ones=0.
REQ-032 MUL: start, a all 1s, b = 1010... (16 ones), ready=2'b11 for 32 cycles -> done asserts; result_ones=16; y_cnt=32.
REQ-033 ADD: a 32 ones, b 32 zeros, ready=2'b11 -> final result_ones=16. MIN: a = 8 ones then 0s, b = 24 ones then 0s -> final result_ones=8.
REQ-034 Skewed: ready=2'b01 for 32 cycles, then 2'b10 for 32 cycles, a=b=all 1s, MAX -> FLUSH is entered if y_cnt<32; done with y_cnt=32 and result_ones=32.
REQ-035 Overflow: after a_cnt=32, pulse ready[0] -> err=1 on the next cycle and stays 1 until the next start or reset; a_ones is unchanged.
REQ-036 Mid-operation: reset low after 10 RUN cycles -> next cycle IDLE, all outputs 0. start in RUN -> ignored, counters unchanged.

Source files
------------

// File: rtl/unary_bounded_arith.sv
// unary_bounded_arith: bit-serial unary MUL/ADD/MIN/MAX that emits result
// bits early, steered by running lower/upper bounds of the final value.
module unary_bounded_arith #(
    parameter int STREAM_LEN  = 32,
    parameter int EPSILON     = 2,
    parameter int COUNT_WIDTH = $clog2(STREAM_LEN + 1)
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    input  logic [1:0]             mode,
    input  logic                   a,
    input  logic                   b,
    input  logic [1:0]             ready,
    output logic                   y,
    output logic                   valid,
    output logic                   done,
    output logic [COUNT_WIDTH-1:0] result_ones,
    output logic                   err
);

    localparam int PW    = 2 * COUNT_WIDTH;
    localparam int SHIFT = $clog2(STREAM_LEN);

    localparam logic [COUNT_WIDTH-1:0] LEN    = COUNT_WIDTH'(STREAM_LEN);
    localparam logic [PW-1:0]          LEN_W  = PW'(STREAM_LEN);
    localparam logic [PW-1:0]          LEN_M1 = PW'(STREAM_LEN - 1);
    localparam logic [PW-1:0]          ONE_W  = PW'(1);
    localparam logic [PW-1:0]          EPS_W  = PW'(EPSILON);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        FLUSH,
        DONE
    } state_t;

    typedef enum logic [1:0] {
        MUL,
        ADD,
        MIN,
        MAX
    } op_t;

    state_t state, state_nxt;
    op_t    op, op_nxt;

    logic [COUNT_WIDTH-1:0] a_ones, a_ones_nxt;
    logic [COUNT_WIDTH-1:0] a_cnt, a_cnt_nxt;
    logic [COUNT_WIDTH-1:0] b_ones, b_ones_nxt;
    logic [COUNT_WIDTH-1:0] b_cnt, b_cnt_nxt;
    logic [COUNT_WIDTH-1:0] y_cnt, y_cnt_nxt;
    logic [COUNT_WIDTH-1:0] result_nxt;
    logic                   err_nxt;
    logic                   y_nxt;
    logic                   valid_nxt;

    logic [PW-1:0] lo_a, hi_a, lo_b, hi_b;
    logic [PW-1:0] lo, hi;
    logic [PW-1:0] r_w, dl, dh, gap;

    logic dec_emit, dec_bit;
    logic emit_go, emit_bit;
    logic a_full, b_full, ovf;

    assign a_full = (a_cnt == LEN);
    assign b_full = (b_cnt == LEN);
    assign ovf    = (ready[0] && a_full) || (ready[1] && b_full);
    assign done   = (state == DONE);

    // Bounds of the final result given the bits still outstanding.
    always_comb begin
        lo_a = PW'(a_ones);
        hi_a = PW'(a_ones) + LEN_W - PW'(a_cnt);
        lo_b = PW'(b_ones);
        hi_b = PW'(b_ones) + LEN_W - PW'(b_cnt);
        lo   = '0;
        hi   = '0;
        unique case (op)
            MUL: begin
                lo = (lo_a * lo_b) >> SHIFT;
                hi = (hi_a * hi_b + LEN_M1) >> SHIFT;
            end
            ADD: begin
                lo = (lo_a + lo_b) >> 1;
                hi = (hi_a + hi_b + ONE_W) >> 1;
            end
            MIN: begin
                lo = (lo_a < lo_b) ? lo_a : lo_b;
                hi = (hi_a < hi_b) ? hi_a : hi_b;
            end
            MAX: begin
                lo = (lo_a > lo_b) ? lo_a : lo_b;
                hi = (hi_a > hi_b) ? hi_a : hi_b;
            end
            default: begin
                lo = '0;
                hi = '0;
            end
        endcase
    end

    always_comb begin
        r_w      = PW'(result_ones);
        dl       = r_w - lo;
        dh       = hi - r_w;
        gap      = (dl > dh) ? (dl - dh) : (dh - dl);
        dec_emit = 1'b1;
        dec_bit  = 1'b0;
        if (r_w < lo) begin
            dec_bit = 1'b1;
        end else if (r_w >= hi) begin
            dec_bit = 1'b0;
        end else if (gap <= EPS_W) begin
            dec_emit = 1'b0;
        end else begin
            dec_bit = (dl < dh);
        end
    end

    // FLUSH has lo == hi, so it simply walks result_ones toward lo.
    always_comb begin
        emit_go  = 1'b0;
        emit_bit = 1'b0;
        if (state == FLUSH) begin
            emit_go  = 1'b1;
            emit_bit = (r_w < lo);
        end else if (state == RUN && |ready && y_cnt < LEN && dec_emit) begin
            emit_go  = 1'b1;
            emit_bit = dec_bit;
        end
    end

    always_comb begin
        state_nxt  = state;
        op_nxt     = op;
        a_ones_nxt = a_ones;
        a_cnt_nxt  = a_cnt;
        b_ones_nxt = b_ones;
        b_cnt_nxt  = b_cnt;
        y_cnt_nxt  = y_cnt;
        result_nxt = result_ones;
        err_nxt    = err;
        y_nxt      = y;
        valid_nxt  = 1'b0;

        if (emit_go) begin
            y_nxt      = emit_bit;
            valid_nxt  = 1'b1;
            y_cnt_nxt  = y_cnt + 1'b1;
            result_nxt = result_ones + COUNT_WIDTH'(emit_bit);
        end

        unique case (state)
            IDLE, DONE: begin
                if (start) begin
                    state_nxt  = RUN;
                    op_nxt     = op_t'(mode);
                    a_ones_nxt = '0;
                    a_cnt_nxt  = '0;
                    b_ones_nxt = '0;
                    b_cnt_nxt  = '0;
                    y_cnt_nxt  = '0;
                    result_nxt = '0;
                    err_nxt    = 1'b0;
                end else if (state == DONE && ovf) begin
                    err_nxt = 1'b1;
                end
            end
            RUN: begin
                if (ready[0] && !a_full) begin
                    a_cnt_nxt  = a_cnt + 1'b1;
                    a_ones_nxt = a_ones + COUNT_WIDTH'(a);
                end
                if (ready[1] && !b_full) begin
                    b_cnt_nxt  = b_cnt + 1'b1;
                    b_ones_nxt = b_ones + COUNT_WIDTH'(b);
                end
                if (ovf) begin
                    err_nxt = 1'b1;
                end
                if (a_full && b_full) begin
                    state_nxt = (y_cnt_nxt == LEN) ? DONE : FLUSH;
                end
            end
            FLUSH: begin
                if (ovf) begin
                    err_nxt = 1'b1;
                end
                if (y_cnt_nxt == LEN) begin
                    state_nxt = DONE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state       <= IDLE;
            op          <= MUL;
            a_ones      <= '0;
            a_cnt       <= '0;
            b_ones      <= '0;
            b_cnt       <= '0;
            y_cnt       <= '0;
            result_ones <= '0;
            err         <= 1'b0;
            y           <= 1'b0;
            valid       <= 1'b0;
        end else begin
            state       <= state_nxt;
            op          <= op_nxt;
            a_ones      <= a_ones_nxt;
            a_cnt       <= a_cnt_nxt;
            b_ones      <= b_ones_nxt;
            b_cnt       <= b_cnt_nxt;
            y_cnt       <= y_cnt_nxt;
            result_ones <= result_nxt;
            err         <= err_nxt;
            y           <= y_nxt;
            valid       <= valid_nxt;
        end
    end

endmodule

// File: tb/tb_unary_bounded_arith.sv
// tb_unary_bounded_arith: directed and random scenarios checked against
// an integer-arithmetic reference model of the unary bounded operator.
module tb_unary_bounded_arith;

    localparam int L   = 32;
    localparam int EPS = 2;
    localparam int CW  = $clog2(L + 1);

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          start = 1'b0;
    logic [1:0]    mode = 2'b00;
    logic          a = 1'b0;
    logic          b = 1'b0;
    logic [1:0]    ready = 2'b00;
    logic          y;
    logic          valid;
    logic          done;
    logic [CW-1:0] result_ones;
    logic          err;

    int errors = 0;
    int checks = 0;

    // reference model state: phase 0 idle, 1 run, 2 flush, 3 done
    int   m_ph = 0;
    int   m_mode = 0;
    int   ma1 = 0, mac = 0, mb1 = 0, mbc = 0;
    int   myc = 0, m_r = 0;
    logic m_y = 1'b0, m_valid = 1'b0, m_err = 1'b0;

    always #5 clk = ~clk;

    unary_bounded_arith #(
        .STREAM_LEN(L),
        .EPSILON(EPS)
    ) dut (
        .clk(clk),
        .reset(reset),
        .start(start),
        .mode(mode),
        .a(a),
        .b(b),
        .ready(ready),
        .y(y),
        .valid(valid),
        .done(done),
        .result_ones(result_ones),
        .err(err)
    );

    function automatic logic [CW+3:0] exp_vec();
        return {m_y, m_valid, logic'(m_ph == 3), m_err, CW'(m_r)};
    endfunction

    task automatic model_edge(input logic rv, input logic st,
                              input logic [1:0] md, input logic [1:0] rdy,
                              input logic av, input logic bv);
        int la, ha, lb, hb, lo, hi, dl, dh, gap;
        bit go, bt, full;
        if (!rv) begin
            m_ph = 0; m_mode = 0;
            ma1 = 0; mac = 0; mb1 = 0; mbc = 0;
            myc = 0; m_r = 0;
            m_y = 0; m_valid = 0; m_err = 0;
            return;
        end
        la = ma1; ha = ma1 + L - mac;
        lb = mb1; hb = mb1 + L - mbc;
        case (m_mode)
            0: begin lo = (la * lb) / L; hi = (ha * hb + L - 1) / L; end
            1: begin lo = (la + lb) / 2; hi = (ha + hb + 1) / 2; end
            2: begin lo = (la < lb) ? la : lb; hi = (ha < hb) ? ha : hb; end
            default: begin lo = (la > lb) ? la : lb; hi = (ha > hb) ? ha : hb; end
        endcase
        m_valid = 0;
        go = 0;
        bt = 0;
        if (m_ph == 0 || m_ph == 3) begin
            if (st) begin
                m_ph = 1; m_mode = int'(md);
                ma1 = 0; mac = 0; mb1 = 0; mbc = 0;
                myc = 0; m_r = 0; m_err = 0;
            end else if (m_ph == 3) begin
                if ((rdy[0] && mac == L) || (rdy[1] && mbc == L)) m_err = 1;
            end
            return;
        end
        if (m_ph == 2) begin
            go = 1;
            bt = (m_r < lo);
        end else if (rdy != 2'b00 && myc < L) begin
            if (m_r < lo) begin
                go = 1; bt = 1;
            end else if (m_r >= hi) begin
                go = 1; bt = 0;
            end else begin
                dl = m_r - lo;
                dh = hi - m_r;
                gap = (dl > dh) ? dl - dh : dh - dl;
                if (gap > EPS) begin
                    go = 1; bt = (dl < dh);
                end
            end
        end
        full = (mac == L) && (mbc == L);
        if (rdy[0]) begin
            if (mac < L) begin mac++; ma1 += int'(av); end
            else m_err = 1;
        end
        if (rdy[1]) begin
            if (mbc < L) begin mbc++; mb1 += int'(bv); end
            else m_err = 1;
        end
        if (go) begin
            m_y = bt; m_valid = 1; myc++; m_r += int'(bt);
        end
        if (m_ph == 1 && full) m_ph = (myc == L) ? 3 : 2;
        else if (m_ph == 2 && myc == L) m_ph = 3;
    endtask

    task automatic step(input logic rv, input logic st, input logic [1:0] md,
                        input logic [1:0] rdy, input logic av, input logic bv);
        reset = rv; start = st; mode = md; ready = rdy; a = av; b = bv;
        @(posedge clk);
        model_edge(rv, st, md, rdy, av, bv);
        #1;
    endtask

    task automatic test_reset();
        for (int i = 0; i < 2; i++) begin
            step(0, 1'($urandom), 2'($urandom), 2'($urandom),
                 1'($urandom), 1'($urandom));
            checks++;
            if ({y, valid, done, err, result_ones} !== '0) begin
                errors++;
                $display("FAIL reset: got %h want 0",
                         {y, valid, done, err, result_ones});
            end
        end
        step(1, 0, 0, 2'b11, 1, 1);
        checks++;
        if ({y, valid, done, err, result_ones} !== exp_vec()) begin
            errors++;
            $display("FAIL idle_ignore: got %h want %h",
                     {y, valid, done, err, result_ones}, exp_vec());
        end
    endtask

    task automatic run_pattern(input string name, input logic [1:0] md,
                               input logic [31:0] av, input logic [31:0] bv,
                               input bit skew, output int nv);
        int n;
        nv = 0;
        step(1, 1, md, 2'b00, 0, 0);
        for (int i = 0; i < (skew ? 2 * L : L); i++) begin
            if (!skew) step(1, 0, md, 2'b11, av[i], bv[i]);
            else if (i < L) step(1, 0, md, 2'b01, av[i], 0);
            else step(1, 0, md, 2'b10, 0, bv[i-L]);
            nv += int'(valid);
            checks++;
            if ({y, valid, done, err, result_ones} !== exp_vec()) begin
                errors++;
                $display("FAIL %s cyc%0d: got %h want %h", name, i,
                         {y, valid, done, err, result_ones}, exp_vec());
            end
        end
        n = 0;
        while (!done && n < 100) begin
            step(1, 0, md, 2'b00, 0, 0);
            nv += int'(valid);
            n++;
            checks++;
            if ({y, valid, done, err, result_ones} !== exp_vec()) begin
                errors++;
                $display("FAIL %s tail%0d: got %h want %h", name, n,
                         {y, valid, done, err, result_ones}, exp_vec());
            end
        end
        checks++;
        if (done !== 1'b1) begin
            errors++;
            $display("FAIL %s_done: got %b want 1", name, done);
        end
    endtask

    task automatic test_mul();
        int nv;
        run_pattern("mul", 2'd0, 32'hFFFF_FFFF, 32'h5555_5555, 0, nv);
        checks++;
        if (result_ones !== CW'(16)) begin
            errors++;
            $display("FAIL mul_ones: got %0d want 16", result_ones);
        end
        checks++;
        if (nv != 32 || dut.y_cnt !== CW'(32)) begin
            errors++;
            $display("FAIL mul_bits: got %0d/%0d want 32", nv, dut.y_cnt);
        end
    endtask

    task automatic test_add();
        int nv;
        run_pattern("add", 2'd1, 32'hFFFF_FFFF, 32'h0, 0, nv);
        checks++;
        if (result_ones !== CW'(16)) begin
            errors++;
            $display("FAIL add_ones: got %0d want 16", result_ones);
        end
        checks++;
        if (nv != 32) begin
            errors++;
            $display("FAIL add_bits: got %0d want 32", nv);
        end
    endtask

    task automatic test_min();
        int nv;
        run_pattern("min", 2'd2, 32'h0000_00FF, 32'h00FF_FFFF, 0, nv);
        checks++;
        if (nv != 32) begin
            errors++;
            $display("FAIL min_bits: got %0d want 32", nv);
        end
    endtask

    task automatic test_skewed();
        int nv;
        run_pattern("skew", 2'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1, nv);
        checks++;
        if (result_ones !== CW'(32) || nv != 32) begin
            errors++;
            $display("FAIL skew_final: got %0d/%0d want 32/32",
                     result_ones, nv);
        end
    endtask

    task automatic test_overflow();
        int n;
        step(1, 1, 2'd3, 2'b00, 0, 0);
        for (int i = 0; i < L; i++) begin
            step(1, 0, 2'd3, 2'b01, 1, 0);
            checks++;
            if ({y, valid, done, err, result_ones} !== exp_vec()) begin
                errors++;
                $display("FAIL ovf_fill%0d: got %h want %h", i,
                         {y, valid, done, err, result_ones}, exp_vec());
            end
        end
        step(1, 0, 2'd3, 2'b01, 1, 0);
        checks++;
        if (err !== 1'b1 || dut.a_ones !== CW'(32)) begin
            errors++;
            $display("FAIL ovf_err: got err=%b a_ones=%0d want 1/32",
                     err, dut.a_ones);
        end
        for (int i = 0; i < L; i++) begin
            step(1, 0, 2'd3, 2'b10, 0, 1'($urandom));
            checks++;
            if ({y, valid, done, err, result_ones} !== exp_vec()) begin
                errors++;
                $display("FAIL ovf_b%0d: got %h want %h", i,
                         {y, valid, done, err, result_ones}, exp_vec());
            end
        end
        n = 0;
        while (!done && n < 100) begin
            step(1, 0, 2'd3, 2'b00, 0, 0);
            n++;
        end
        checks++;
        if (done !== 1'b1 || err !== 1'b1) begin
            errors++;
            $display("FAIL ovf_sticky: got done=%b err=%b want 1/1",
                     done, err);
        end
        step(1, 1, 2'd0, 2'b00, 0, 0);
        checks++;
        if (err !== 1'b0 || {y, valid, done, err, result_ones} !== exp_vec()) begin
            errors++;
            $display("FAIL ovf_clear: got %h want %h",
                     {y, valid, done, err, result_ones}, exp_vec());
        end
    endtask

    task automatic test_midop();
        int pre_a;
        step(0, 0, 0, 2'b00, 0, 0);
        step(1, 1, 2'd1, 2'b00, 0, 0);
        for (int i = 0; i < 10; i++) begin
            step(1, 0, 2'd1, 2'($urandom), 1'($urandom), 1'($urandom));
            checks++;
            if ({y, valid, done, err, result_ones} !== exp_vec()) begin
                errors++;
                $display("FAIL mid_run%0d: got %h want %h", i,
                         {y, valid, done, err, result_ones}, exp_vec());
            end
        end
        pre_a = mac;
        step(1, 1, 2'd2, 2'b00, 0, 0);
        checks++;
        if (dut.a_cnt !== CW'(pre_a) ||
            {y, valid, done, err, result_ones} !== exp_vec()) begin
            errors++;
            $display("FAIL start_ignored: got a_cnt=%0d want %0d",
                     dut.a_cnt, pre_a);
        end
        step(0, 1'($urandom), 2'($urandom), 2'b11, 1, 1);
        checks++;
        if ({y, valid, done, err, result_ones} !== '0 ||
            dut.a_cnt !== '0 || dut.y_cnt !== '0) begin
            errors++;
            $display("FAIL mid_reset: got %h a_cnt=%0d want 0",
                     {y, valid, done, err, result_ones}, dut.a_cnt);
        end
        step(1, 0, 0, 2'b00, 0, 0);
    endtask

    task automatic test_back_to_back();
        logic [1:0] md;
        int n;
        for (int k = 0; k < 6; k++) begin
            md = 2'($urandom);
            step(1, 1, md, 2'b00, 0, 0);
            checks++;
            if ({y, valid, done, err, result_ones} !== exp_vec()) begin
                errors++;
                $display("FAIL b2b_start%0d: got %h want %h", k,
                         {y, valid, done, err, result_ones}, exp_vec());
            end
            n = 0;
            while (!done && n < 400) begin
                step(1, 0, md, 2'($urandom | $urandom),
                     1'($urandom), 1'($urandom));
                n++;
                checks++;
                if ({y, valid, done, err, result_ones} !== exp_vec()) begin
                    errors++;
                    $display("FAIL b2b%0d cyc%0d: got %h want %h", k, n,
                             {y, valid, done, err, result_ones}, exp_vec());
                end
            end
            checks++;
            if (done !== 1'b1) begin
                errors++;
                $display("FAIL b2b%0d_timeout: got done=%b want 1", k, done);
            end
        end
    endtask

    initial begin
        test_reset();
        test_mul();
        test_add();
        test_min();
        test_skewed();
        test_overflow();
        test_midop();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
